memory_access: RTL
==================

// Module: memory_access
// PURPOSE
// - MEM stage of the 5-stage RV64 pipeline; consumes the ex_mem register written by execute, produces mem_wb.
// - Runs the data-bus (dreq/dresp) handshake for loads/stores: store byte strobes, load byte-lane extract plus sign/zero extension.
// - Drives the MEM->EX forwarding path (reg_writer) and an ok bit that stalls the pipeline while a bus access is pending.
// PARAMETERS
// - XLEN         64   datapath width; dreq.data/dresp.data are XLEN wide
// - ADDR_LSB     3    log2(XLEN/8); address bits selecting the byte lane
// PORTS
// - clk            in   1       clock
// - reset          in   1       synchronous, active-high
// - ex_mem_state   in   struct  ex_mem pipeline register (op, inst, inst_pc, valid, alu_result, write_mem_data, csr, jump, inst_counter)
// - step           in   1       pipeline advances at this edge (all stages ok)
// - mem_wb_state   out  struct  mem_wb register contents (inst, inst_pc, valid, op, result, csr, inst_counter)
// - forward        out  struct  reg_writer {reg_write_enable, reg_dest_addr, reg_write_data} to execute
// - ok             out  1       stage finished; pipeline may advance
// - dreq_valid     out  1       data request valid
// - dreq_addr      out  64      byte address = ex_mem_state.alu_result
// - dreq_size      out  3       MSIZE1/2/4/8 encoding
// - dreq_strobe    out  8       byte write enables; 0 for loads
// - dreq_data      out  64      store data, lane-shifted
// - dresp_addr_ok  in   1       address accepted (informational)
// - dresp_data_ok  in   1       access complete; dresp_data valid this cycle
// - dresp_data     in   64      load data, aligned to 8-byte word
// BEHAVIOUR
// - Reset: state=IDLE, dreq_valid=0, dreq_strobe=0, ok=0, forward.reg_write_enable=0, latched data=0.
// - FSM IDLE -> REQ: ex_mem_state.valid && mem op && aligned. REQ -> DONE: dresp_data_ok. DONE -> IDLE: step.
// - Other ops: stay IDLE, ok=1 combinationally, result=alu_result, zero added latency.
// - REQ: dreq_valid=1; addr/size/strobe/data held stable until data_ok cycle. dreq_valid deasserts the cycle after data_ok.
// - dresp_data latched on data_ok. ok=1 from the data_ok cycle (bypass) through DONE until step.
// - One outstanding access max; no new request while in DONE.
// - Lane select k=addr[2:0]. Store strobe: sb 8'h01<<k, sh 8'h03<<k, sw 8'h0F<<k, sd 8'hFF.
// - Store data = write_mem_data << (8*k).
// - Load: raw = dresp_data >> (8*k); lb/lh/lw sign-extend bit 7/15/31; lbu/lhu/lwu zero-extend; ld unchanged.
// - Misaligned (half k[0]!=0, word k[1:0]!=0, double k!=0): no bus request, ok=1, reg write suppressed.
// - Forward: enable = valid && (arith || csr || load done) && rd!=0; data = load result or alu_result.
// - Forward enable is 0 while a load sits in REQ.
// - Pass-through: inst, inst_pc, valid, op, csr, inst_counter go straight to mem_wb_state.
// - valid=0 bubble: no request, ok=1, forward disabled.
// - Reset mid-REQ: -> IDLE next edge, dreq_valid=0; a data_ok arriving after reset is ignored.
// - step while not ok is illegal (upstream guarantees).
// TESTING
// - add x5 (alu_result=0x1234) -> ok=1 same cycle, no dreq_valid, forward {1,5,0x1234}.
// - ld addr=0x80001000, data_ok after 3 cycles with 0xDEADBEEF_CAFEF00D.
//   -> dreq_valid high 3 cycles, size=8; result 0xDEADBEEFCAFEF00D; ok on the data_ok cycle.
// - lb addr=...1005, dresp_data=0x0000_80FF_0000_0000 -> result 0xFFFF_FFFF_FFFF_FF80.
//   - Same access as lbu -> 0x80.
// - sh addr=...1002, write_mem_data=0xABCD -> strobe 8'h0C, dreq_data=0x0000_0000_ABCD_0000; no forward.
// - reset asserted while in REQ, then data_ok -> dreq_valid=0 next cycle, ok=0, state IDLE, response ignored.
// - lw addr=...1002 (misaligned) -> no dreq_valid, ok=1, forward.reg_write_enable=0.

Source files
------------

// File: rtl/memory_access.sv
// MEM stage of the RV64 pipeline: data-bus handshake for loads/stores, byte-lane
// steering with load extension, MEM->EX forwarding and the stage-ready (ok) bit.
package memory_access_pkg;

  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_CSR, OP_JUMP,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } op_t;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;

  typedef struct packed {
    logic        csr_write;
    logic [11:0] csr_addr;
    logic [63:0] csr_data;
  } csr_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        valid;
    logic [63:0] alu_result;
    logic [63:0] write_mem_data;
    csr_t        csr;
    logic        jump;
    logic [63:0] inst_counter;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        valid;
    op_t         op;
    logic [63:0] result;
    csr_t        csr;
    logic [63:0] inst_counter;
  } mem_wb_t;

  typedef struct packed {
    logic        reg_write_enable;
    logic [4:0]  reg_dest_addr;
    logic [63:0] reg_write_data;
  } reg_writer_t;

endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ADDR_LSB = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  ex_mem_t           ex_mem_state,
  input  logic              step,
  output mem_wb_t           mem_wb_state,
  output reg_writer_t       forward,
  output logic              ok,
  output logic              dreq_valid,
  output logic [XLEN-1:0]   dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [XLEN/8-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data
);

  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state;
  logic [XLEN-1:0]     data_q;
  logic [ADDR_LSB-1:0] k;
  logic [4:0]          rd;
  logic                is_load, is_store, misaligned, start, resp_now, load_done;
  logic [2:0]          size;
  logic [STRB_W-1:0]   mask;
  logic [XLEN-1:0]     load_raw, load_ext, result;
  logic                unused_bits;

  assign k           = ex_mem_state.alu_result[ADDR_LSB-1:0];
  assign rd          = ex_mem_state.inst[11:7];
  assign unused_bits = ^{dresp_addr_ok, ex_mem_state.jump};

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    size       = MSIZE1;
    mask       = '0;
    case (ex_mem_state.op)
      OP_LB, OP_LBU, OP_SB: begin
        size = MSIZE1;
        mask = STRB_W'(8'h01);
      end
      OP_LH, OP_LHU, OP_SH: begin
        size       = MSIZE2;
        mask       = STRB_W'(8'h03);
        misaligned = k[0];
      end
      OP_LW, OP_LWU, OP_SW: begin
        size       = MSIZE4;
        mask       = STRB_W'(8'h0F);
        misaligned = (k[1:0] != 2'b00);
      end
      OP_LD, OP_SD: begin
        size       = MSIZE8;
        mask       = '1;
        misaligned = (k != '0);
      end
      default: ;
    endcase
    case (ex_mem_state.op)
      OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU: is_load  = 1'b1;
      OP_SB, OP_SH, OP_SW, OP_SD:                         is_store = 1'b1;
      default: ;
    endcase
  end

  assign start    = (state == IDLE) && ex_mem_state.valid && (is_load || is_store) && !misaligned;
  assign resp_now = (state == REQ) && dresp_data_ok;

  assign dreq_addr   = ex_mem_state.alu_result;
  assign dreq_size   = size;
  assign dreq_strobe = (dreq_valid && is_store) ? (mask << k) : '0;
  assign dreq_data   = ex_mem_state.write_mem_data << {k, 3'b000};

  // Response data is used directly on the data_ok cycle so ok/forward need no extra cycle.
  always_comb begin
    load_raw = (resp_now ? dresp_data : data_q) >> {k, 3'b000};
    case (ex_mem_state.op)
      OP_LB:   load_ext = {{(XLEN-8){load_raw[7]}},   load_raw[7:0]};
      OP_LH:   load_ext = {{(XLEN-16){load_raw[15]}}, load_raw[15:0]};
      OP_LW:   load_ext = {{(XLEN-32){load_raw[31]}}, load_raw[31:0]};
      OP_LBU:  load_ext = {{(XLEN-8){1'b0}},          load_raw[7:0]};
      OP_LHU:  load_ext = {{(XLEN-16){1'b0}},         load_raw[15:0]};
      OP_LWU:  load_ext = {{(XLEN-32){1'b0}},         load_raw[31:0]};
      default: load_ext = load_raw;
    endcase
  end

  assign load_done = is_load && (resp_now || (state == DONE));
  assign result    = load_done ? load_ext : ex_mem_state.alu_result;
  assign ok        = !reset && ((state == DONE) || resp_now || ((state == IDLE) && !start));

  always_comb begin
    forward.reg_write_enable = !reset && ex_mem_state.valid && (rd != '0) &&
                               ((ex_mem_state.op == OP_ALU) || (ex_mem_state.op == OP_CSR) || load_done);
    forward.reg_dest_addr    = rd;
    forward.reg_write_data   = result;
  end

  always_comb begin
    mem_wb_state.inst         = ex_mem_state.inst;
    mem_wb_state.inst_pc      = ex_mem_state.inst_pc;
    mem_wb_state.valid        = ex_mem_state.valid;
    mem_wb_state.op           = ex_mem_state.op;
    mem_wb_state.result       = result;
    mem_wb_state.csr          = ex_mem_state.csr;
    mem_wb_state.inst_counter = ex_mem_state.inst_counter;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dreq_valid <= 1'b0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= REQ;
          dreq_valid <= 1'b1;
        end
        REQ: if (dresp_data_ok) begin
          data_q     <= dresp_data;
          dreq_valid <= 1'b0;
          // A step on the data_ok edge already retires this access, so skip DONE.
          state      <= step ? IDLE : DONE;
        end
        DONE: if (step) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
